mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of all ports.
REQ-002 Parameter: MAX_WAIT, 15, maximum cycles an access waits for mem_ready before abort (1..255).
REQ-003 clk  in  1  clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 if_req / if_addr  in  1 / ADDR_W  fetch-port read request and address.
REQ-006 if_rdata / if_ack  out  32 / 1  fetch read data and completion pulse.
REQ-007 dm_req / dm_we / dm_addr / dm_wdata  in  1 / 4 / ADDR_W / 32  data-port request, byte write enables (0 = read), address, write data.
REQ-008 dm_rdata / dm_ack  out  32 / 1  data-port read data and completion pulse.
REQ-009 mem_req / mem_we / mem_addr / mem_wdata  out  1 / 4 / ADDR_W / 32  shared single-port memory request.
REQ-010 mem_rdata / mem_ready  in  32 / 1  memory read data and completion, valid in the same cycle.
REQ-011 bus_err  out  1  one-cycle pulse on access timeout.

Function
REQ-012 FSM states SHALL be IDLE, IF_ACC, DM_ACC, DONE.
REQ-013 IDLE: dm_req -> DM_ACC; else if_req -> IF_ACC; else stay; without MEM_ARB_RR_EN, dm wins when both request.
REQ-014 On leaving IDLE, addr/we/wdata of the granted port SHALL be latched; mem_* outputs drive latched values only.
REQ-015 mem_req SHALL be 1 exactly in IF_ACC/DM_ACC; mem_we forced 0 in IF_ACC.
REQ-016 In an ACC state, mem_ready=1 -> capture mem_rdata into granted port's rdata register, go DONE.
REQ-017 Wait counter SHALL clear on ACC entry, increment each ACC cycle without mem_ready; reaching MAX_WAIT -> rdata register 0, bus_err pulse, go DONE.
REQ-018 mem_ready in the same cycle as counter reaching MAX_WAIT: completion wins, no bus_err.
REQ-019 DONE: granted port's ack = 1 for one cycle, then IDLE; requesters drop req in the ack cycle.
REQ-020 Minimum latency: req seen in IDLE cycle 0, mem_req cycle 1, mem_ready cycle 1 -> ack cycle 2.
REQ-021 if_rdata/dm_rdata SHALL hold until overwritten by the next completion of that port; dm write access leaves dm_rdata unchanged.
REQ-022 Requests SHALL be ignored outside IDLE; changes to inputs during an access do not affect mem_*.
REQ-023 mem_ready outside ACC states SHALL be ignored.

Reset
REQ-024 rst SHALL force IDLE, counter 0, last-grant = IF, all outputs 0 (including rdata registers) asynchronously.
REQ-025 rst mid-access SHALL abort with no ack and no bus_err; mem_req drops immediately.

Configuration
REQ-026 Macro MEM_ARB_RR_EN defined: on simultaneous requests in IDLE, grant the port not granted last; single requests granted as usual.
REQ-027 MEM_ARB_RR_EN undefined: fixed dm priority, last-grant register removed.

Structure
REQ-028 Shared package: FSM state encoding (2-bit), port-select constants IF/DM, MAX_WAIT default.
REQ-029 One sub-module mem_arb_timer (load/increment/expire counter); FSM and datapath latches stay in mem_arbiter.

Verification
REQ-030 if_req=1, if_addr=0x10, mem_ready at first ACC cycle, mem_rdata=0x00500093 -> mem_addr=0x10 cycle 1, if_ack and if_rdata=0x00500093 cycle 2.
REQ-031 dm_req write dm_we=4'b1111, addr=0x100, wdata=0xDEADBEEF, mem_ready after 3 cycles -> mem_we=4'b1111 for 3 cycles, dm_ack cycle after ready, dm_rdata unchanged.
REQ-032 if_req and dm_req same cycle, fixed priority -> DM served first, IF served next; with MEM_ARB_RR_EN and last grant DM -> IF first.
REQ-033 mem_ready never asserted, MAX_WAIT=15 -> bus_err and ack pulse after 15 ACC cycles, rdata=0.
REQ-034 rst asserted during DM_ACC -> mem_req 0 same cycle, no dm_ack; after release fresh if_req served normally.
REQ-035 mem_ready asserted in IDLE with no request -> no ack, no state change.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM encoding, port-select constants and timeout default for mem_arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, IF_ACC = 2'd1, DM_ACC = 2'd2, DONE = 2'd3} state_t;
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;
  localparam int MAX_WAIT_DEF = 15;
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: access wait counter, cleared outside an access, expires on the MAX_WAIT-th stalled cycle
module mem_arb_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expire
);
  logic [7:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (inc) cnt <= cnt + 8'd1;
  assign expire = cnt == 8'(MAX_WAIT - 1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data port arbiter onto one single-port memory with access timeout.
// Define MEM_ARB_RR_EN to alternate grants on simultaneous requests (default: data port wins).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic [3:0]        dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_ack,
  output logic              mem_req,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              bus_err
);
  state_t state, nxt;
  logic sel, acc, expire, dm_pick, finish;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0] we_q;
  logic [31:0] wdata_q, rd_val;
  assign acc = state == IF_ACC || state == DM_ACC;
  assign finish = acc && (mem_ready || expire);
  assign rd_val = mem_ready ? mem_rdata : '0;
`ifdef MEM_ARB_RR_EN
  // sel still holds the previous grant while idle, so it doubles as last-grant
  assign dm_pick = dm_req && !(if_req && sel == PORT_DM);
`else
  assign dm_pick = dm_req;
`endif
  mem_arb_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk(clk), .rst(rst), .clear(!acc), .inc(acc && !mem_ready), .expire(expire)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:           nxt = dm_pick ? DM_ACC : if_req ? IF_ACC : IDLE;
      IF_ACC, DM_ACC: nxt = finish ? DONE : state;
      default:        nxt = IDLE;
    endcase
  end
  always_comb begin
    mem_req = acc;
    mem_we  = state == DM_ACC ? we_q : '0;
    if_ack  = state == DONE && sel == PORT_IF;
    dm_ack  = state == DONE && sel == PORT_DM;
  end
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sel      <= PORT_IF;
      addr_q   <= '0;
      we_q     <= '0;
      wdata_q  <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
      bus_err  <= 1'b0;
    end else begin
      if (state == IDLE && (if_req || dm_req)) begin
        sel     <= dm_pick ? PORT_DM : PORT_IF;
        addr_q  <= dm_pick ? dm_addr : if_addr;
        we_q    <= dm_pick ? dm_we : '0;
        wdata_q <= dm_pick ? dm_wdata : '0;
      end
      if (finish && state == IF_ACC) if_rdata <= rd_val;
      if (finish && state == DM_ACC && we_q == '0) dm_rdata <= rd_val;
      bus_err <= acc && !mem_ready && expire;
    end
endmodule
